// File: rtl/screen_bg_pkg.sv
// Shared types and constants for the VGA background generator.
package screen_bg_pkg;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    FRAME    = 2'd1,
    GRADIENT = 2'd2,
    FADE     = 2'd3
  } bg_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADING = 2'd1,
    HOLD   = 2'd2
  } fade_state_t;

  localparam logic [7:0] BLACK   = 8'h00;
  localparam logic [7:0] WHITE   = 8'hFF;
  localparam int         LEVEL_W = 3;

endpackage

// File: rtl/rgb332_scale.sv
// Combinational RGB332 brightness scaler: each channel becomes (ch*bright)>>3,
// with bright in 1..8 so bright=8 reproduces the input colour.
module rgb332_scale (
  input  logic [7:0] color_i,
  input  logic [3:0] bright_i,
  output logic [7:0] color_o
);

  logic [6:0] r_p, g_p;
  logic [5:0] b_p;
  logic [2:0] r_s, g_s;
  logic [1:0] b_s;

  assign r_p = {4'b0, color_i[7:5]} * {3'b0, bright_i};
  assign g_p = {4'b0, color_i[4:2]} * {3'b0, bright_i};
  assign b_p = {4'b0, color_i[1:0]} * {2'b0, bright_i};

  // Products never exceed the channel range times 8, so dropping the top bit is lossless.
  assign r_s = 3'(r_p >> 3);
  assign g_s = 3'(g_p >> 3);
  assign b_s = 2'(b_p >> 3);

  assign color_o = {r_s, g_s, b_s};

endmodule

// File: rtl/screen_background.sv
// Full-screen background layer (solid / frame / gradient / fade), registered RGB332 out.
// Fade FSM and FADE mode exist only when BG_FADE_EN is defined; otherwise mode 3 acts as SOLID.
module screen_background
  import screen_bg_pkg::*;
#(
  parameter int unsigned X_SIZE           = 640,
  parameter int unsigned Y_SIZE           = 480,
  parameter int unsigned BORDER_W         = 10,
  parameter logic [7:0]  BASE_COLOR       = 8'h02,
  parameter logic [7:0]  BORDER_COLOR     = 8'hFF,
  parameter int unsigned FADE_STEP_FRAMES = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [1:0]  mode,
  input  logic        fadeTrigger,
  output logic [7:0]  BG_RGB,
  output logic        fadeDone
);

  bg_mode_t   mode_e;
  logic       in_range, border;
  logic [2:0] band;
  logic [7:0] rgb_d, rgb_q;
  logic [7:0] fade_rgb;

  assign mode_e   = bg_mode_t'(mode);
  assign in_range = (pixelX < 11'(X_SIZE)) && (pixelY < 11'(Y_SIZE));
  assign border   = (pixelX < 11'(BORDER_W)) || (pixelX >= 11'(X_SIZE - BORDER_W)) ||
                    (pixelY < 11'(BORDER_W)) || (pixelY >= 11'(Y_SIZE - BORDER_W));
  assign band     = (|pixelY[10:9]) ? 3'd7 : pixelY[8:6];

`ifdef BG_FADE_EN
  localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;

  fade_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q;

  // A trigger in any state restarts from black; it outranks a same-cycle frame pulse.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (fadeTrigger) begin
        state_d = FADING;
        level_d = '0;
        cnt_d   = '0;
      end
      FADING: if (fadeTrigger) begin
        level_d = '0;
        cnt_d   = '0;
      end else if (startOfFrame) begin
        if (cnt_q == CNT_W'(FADE_STEP_FRAMES - 1)) begin
          cnt_d   = '0;
          level_d = level_q + 1'b1;
          if (level_q == LEVEL_W'(6)) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: if (fadeTrigger) begin
        state_d = FADING;
        level_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == HOLD);
    end
  end

  rgb332_scale u_scale (
    .color_i  (BASE_COLOR),
    .bright_i ({1'b0, level_q} + 4'd1),
    .color_o  (fade_rgb)
  );

  assign fadeDone = done_q;
`else
  logic unused_fade_inputs;
  assign unused_fade_inputs = ^{startOfFrame, fadeTrigger};
  assign fade_rgb = BASE_COLOR;
  assign fadeDone = 1'b0;
`endif

  always_comb begin
    rgb_d = BLACK;
    if (in_range) begin
      case (mode_e)
        SOLID:    rgb_d = BASE_COLOR;
        FRAME:    rgb_d = border ? BORDER_COLOR : BASE_COLOR;
        GRADIENT: rgb_d = {band, 3'b000, BASE_COLOR[1:0]};
        FADE:     rgb_d = fade_rgb;
        default:  rgb_d = BASE_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rgb_q <= BLACK;
    else         rgb_q <= rgb_d;
  end

  assign BG_RGB = rgb_q;

endmodule

// File: tb/tb_screen_background.sv
// Directed bench for screen_background: pixel vector table plus fade/reset sequences.
module tb_screen_background;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, fadeTrigger;
  logic [1:0]  mode;
  logic [7:0]  BG_RGB;
  logic        fadeDone;

  int checks = 0;
  int failures = 0;

`ifdef BG_FADE_EN
  localparam logic [7:0] EXP_M3_IDLE = 8'h00;
`else
  localparam logic [7:0] EXP_M3_IDLE = 8'h02;
`endif

  typedef struct {
    logic [1:0]  m;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  screen_background dut (
    .clk          (clk),
    .resetN       (resetN),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .mode         (mode),
    .fadeTrigger  (fadeTrigger),
    .BG_RGB       (BG_RGB),
    .fadeDone     (fadeDone)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock with the given pulses; returns #1 after the edge with pulses cleared.
  task automatic step(input logic sof, input logic trg);
    startOfFrame = sof;
    fadeTrigger  = trg;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    fadeTrigger  = 1'b0;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{2'd0, 11'd100, 11'd100, 8'h02};
    vecs[1]  = '{2'd1, 11'd0,   11'd0,   8'hFF};
    vecs[2]  = '{2'd1, 11'd9,   11'd200, 8'hFF};
    vecs[3]  = '{2'd1, 11'd10,  11'd10,  8'h02};
    vecs[4]  = '{2'd1, 11'd639, 11'd479, 8'hFF};
    vecs[5]  = '{2'd1, 11'd320, 11'd240, 8'h02};
    vecs[6]  = '{2'd1, 11'd630, 11'd240, 8'hFF};
    vecs[7]  = '{2'd1, 11'd629, 11'd469, 8'h02};
    vecs[8]  = '{2'd1, 11'd100, 11'd470, 8'hFF};
    vecs[9]  = '{2'd2, 11'd5,   11'd0,   8'h02};
    vecs[10] = '{2'd2, 11'd5,   11'd130, 8'h42};
    vecs[11] = '{2'd2, 11'd5,   11'd479, 8'hE2};
    vecs[12] = '{2'd2, 11'd640, 11'd0,   8'h00};
    vecs[13] = '{2'd0, 11'd0,   11'd480, 8'h00};
    vecs[14] = '{2'd1, 11'd700, 11'd5,   8'h00};
    vecs[15] = '{2'd3, 11'd100, 11'd100, EXP_M3_IDLE};

    resetN = 1'b0; mode = 2'd0; pixelX = 11'd0; pixelY = 11'd0;
    startOfFrame = 1'b0; fadeTrigger = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", BG_RGB, 8'h00);
    chk("reset_done", {7'b0, fadeDone}, 8'h00);
    #2 resetN = 1'b1;
    step(1'b0, 1'b0);
    chk("first_pixel", BG_RGB, 8'h02);

    for (int i = 0; i < 16; i++) begin
      mode = vecs[i].m; pixelX = vecs[i].x; pixelY = vecs[i].y;
      step(1'b0, 1'b0);
      chk($sformatf("vec%0d", i), BG_RGB, vecs[i].exp);
    end

    mode = 2'd3; pixelX = 11'd100; pixelY = 11'd100;
`ifdef BG_FADE_EN
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("fade_lvl0", BG_RGB, 8'h00);
    chk("fade_start_done", {7'b0, fadeDone}, 8'h00);
    sofs(12); step(1'b0, 1'b0);
    chk("fade_lvl3", BG_RGB, 8'h01);
    sofs(15);
    chk("done_after27", {7'b0, fadeDone}, 8'h00);
    step(1'b0, 1'b0);
    chk("fade_lvl6", BG_RGB, 8'h01);
    sofs(1);
    chk("done_after28", {7'b0, fadeDone}, 8'h01);
    step(1'b0, 1'b0);
    chk("fade_full", BG_RGB, 8'h02);
    step(1'b0, 1'b1);
    chk("hold_retrig_done", {7'b0, fadeDone}, 8'h00);
    step(1'b0, 1'b0);
    chk("hold_retrig_rgb", BG_RGB, 8'h00);

    sofs(20); step(1'b0, 1'b0);
    chk("fade_lvl5", BG_RGB, 8'h01);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("restart_rgb", BG_RGB, 8'h00);
    sofs(27);
    chk("restart_27", {7'b0, fadeDone}, 8'h00);
    sofs(1);
    chk("restart_28", {7'b0, fadeDone}, 8'h01);

    step(1'b0, 1'b1);
    sofs(6);
    step(1'b1, 1'b1);
    sofs(27);
    chk("coinc_27", {7'b0, fadeDone}, 8'h00);
    sofs(1);
    chk("coinc_28", {7'b0, fadeDone}, 8'h01);

    step(1'b0, 1'b1);
    sofs(16); step(1'b0, 1'b0);
    chk("fade_lvl4", BG_RGB, 8'h01);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_rgb", BG_RGB, 8'h00);
    chk("midrst_done", {7'b0, fadeDone}, 8'h00);
    #2 resetN = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_idle", BG_RGB, 8'h00);
    sofs(28);
    chk("idle_ignores_sof", {7'b0, fadeDone}, 8'h00);
    step(1'b0, 1'b0);
    chk("idle_black", BG_RGB, 8'h00);
`else
    step(1'b0, 1'b1);
    sofs(28);
    chk("nofade_done", {7'b0, fadeDone}, 8'h00);
    step(1'b0, 1'b0);
    chk("nofade_mode3", BG_RGB, 8'h02);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_rgb", BG_RGB, 8'h00);
    #2 resetN = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_mode3", BG_RGB, 8'h02);
`endif

    mode = 2'd0;
    step(1'b0, 1'b0);
    chk("mode_switch", BG_RGB, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
